// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS load/store unit.
// MISALIGNED_SPLIT_EN adds the REQ_HI state for two-beat misaligned accesses.
package mips_mem_pkg;

  localparam int MEM_BYTES_DEF = 40;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
`ifdef MISALIGNED_SPLIT_EN
    , ST_REQ_HI
`endif
  } lsu_state_e;

  typedef struct packed {
    logic       we;
    logic [2:0] op;
    logic [1:0] off;
  } lsu_req_t;

  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Stores ignore the sign bit, so only the size field must be legal for them.
  function automatic logic op_legal(input logic [2:0] op, input logic is_store);
    if (op[1:0] == 2'b11) return 1'b0;
    if (is_store)         return 1'b1;
    return !(op[2] && op[1]);
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Word-wide data-memory bus between the LSU (master) and the memory responder (slave).
interface mips_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Lane steering for the LSU: byte enables over a two-word window, rotated store
// data, and load extraction/extension from a {hi, lo} word pair.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);
  logic [7:0]  be_mask;
  logic [7:0]  be_win;
  logic [31:0] rep;
  logic [63:0] rot;
  logic [63:0] rd_win;
  logic [31:0] rd_sh;

  always_comb begin
    be_mask = 8'h0F;
    rep     = wdata_in;
    case (op[1:0])
      2'b00: begin be_mask = 8'h01; rep = {4{wdata_in[7:0]}};  end
      2'b01: begin be_mask = 8'h03; rep = {2{wdata_in[15:0]}}; end
      default: ;
    endcase
    be_win = be_mask << off;
    be_lo  = be_win[3:0];
    be_hi  = be_win[7:4];
    // Rotating the replicated data leaves aligned lanes unchanged and puts the
    // spill-over bytes of a misaligned access in the low lanes of the next word.
    rot    = {rep, rep} << {off, 3'b000};
    wdata  = rot[63:32];
    rd_win = {rdata_hi, rdata_lo} >> {off, 3'b000};
    rd_sh  = rd_win[31:0];
    case (op[1:0])
      2'b00:   rdata_ext = op[2] ? {24'b0, rd_sh[7:0]}  : {{24{rd_sh[7]}},  rd_sh[7:0]};
      2'b01:   rdata_ext = op[2] ? {16'b0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: rdata_ext = rd_sh;
    endcase
  end
endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: turns MemRead/MemWrite into word bus beats, stalls until ack.
// Define MISALIGNED_SPLIT_EN to split misaligned half/word accesses into two beats.
module mips_lsu
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  mem_op,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        fault,
  mips_lsu_if.master  bus
);
  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
`ifdef MISALIGNED_SPLIT_EN
  logic [31:0] lo_q, lo_d;
`endif

  logic [2:0]  al_op;
  logic [1:0]  al_off;
  logic [31:0] al_rd_lo, al_rd_hi, al_wdata, al_rdata;
  logic [3:0]  al_be_lo, al_be_hi;
  logic [2:0]  acc_size;
  logic [32:0] acc_end;
  logic        acc_err;
  logic        timeout_hit;

  // In IDLE the aligner sees the live request; afterwards the latched one.
  always_comb begin
    al_op  = (state_q == ST_IDLE) ? mem_op       : req_q.op;
    al_off = (state_q == ST_IDLE) ? Address[1:0] : req_q.off;
`ifdef MISALIGNED_SPLIT_EN
    al_rd_lo = (state_q == ST_REQ_HI) ? lo_q : bus.bus_rdata;
    al_rd_hi = (state_q == ST_REQ_HI) ? bus.bus_rdata : 32'h0;
`else
    al_rd_lo = bus.bus_rdata;
    al_rd_hi = 32'h0;
`endif
  end

  lsu_lane_align u_align (
    .op       (al_op),
    .off      (al_off),
    .wdata_in (WriteData),
    .rdata_lo (al_rd_lo),
    .rdata_hi (al_rd_hi),
    .be_lo    (al_be_lo),
    .be_hi    (al_be_hi),
    .wdata    (al_wdata),
    .rdata_ext(al_rdata)
  );

  always_comb begin
    acc_size = op_size(mem_op);
    acc_end  = {1'b0, Address} + 33'(acc_size);
    acc_err  = (MemRead && MemWrite) || !op_legal(mem_op, MemWrite) ||
               (acc_end > 33'(MEM_BYTES));
`ifndef MISALIGNED_SPLIT_EN
    // A spill into the next word catches odd halves at offset 3 and all
    // unaligned words; the odd half at offset 1 stays inside one word.
    acc_err = acc_err || (al_be_hi != 4'b0) || (acc_size == SZ_HALF && Address[0]);
`endif
  end

  assign timeout_hit = (cnt_q == 4'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    fault_d     = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
`ifdef MISALIGNED_SPLIT_EN
    lo_d        = lo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (MemRead || MemWrite) begin
          req_d = '{we: MemWrite, op: mem_op, off: Address[1:0]};
          cnt_d = 4'd0;
          if (acc_err) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else begin
            state_d     = ST_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = MemWrite;
            bus_addr_d  = {Address[31:2], 2'b00};
            bus_wdata_d = al_wdata;
            bus_be_d    = al_be_lo;
          end
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ST_REQ, ST_REQ_HI: begin
`else
      ST_REQ: begin
`endif
        if (bus.bus_ack) begin
          cnt_d = 4'd0;
`ifdef MISALIGNED_SPLIT_EN
          if (state_q == ST_REQ && al_be_hi != 4'b0) begin
            state_d    = ST_REQ_HI;
            lo_d       = bus.bus_rdata;
            bus_addr_d = bus_addr_q + 32'd4;
            bus_be_d   = al_be_hi;
          end else
`endif
          begin
            state_d   = ST_DONE;
            bus_req_d = 1'b0;
            if (!req_q.we) rdata_d = al_rdata;
          end
        end else if (timeout_hit) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          fault_d   = 1'b1;
          cnt_d     = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= 4'd0;
      rdata_q     <= 32'h0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
`ifdef MISALIGNED_SPLIT_EN
      lo_q        <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
`ifdef MISALIGNED_SPLIT_EN
      lo_q        <= lo_d;
`endif
    end
  end

  assign stall         = (state_q == ST_IDLE) ? (MemRead | MemWrite) : (state_q != ST_DONE);
  assign fault         = fault_q;
  assign ReadData      = rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;
endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: byte-array memory responder plus a byte-level
// reference model of loads/stores; honours MISALIGNED_SPLIT_EN for expectations.
module tb_mips_lsu;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  mem_op;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        stall, fault;

  mips_lsu_if bus();

  mips_lsu dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_op(mem_op), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .stall(stall), .fault(fault), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0, tests_failed = 0;

  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  logic [31:0] exp_rd;

  // responder state
  int  resp_delay = 0;
  bit  never_ack = 1'b0;
  int  wait_cnt = 0;
  int  beat_n = 0;
  logic [31:0] beat_addr [2];
  logic [3:0]  beat_be [2];
  logic        beat_we [2];
  logic [31:0] beat_wdata [2];
  logic        pend_we;
  logic [31:0] pend_addr, pend_wdata;
  logic [3:0]  pend_be;

  // results of the last do_access
  int   o_stall, o_req;
  logic o_fault;
  logic [31:0] o_rdata;
  bit   o_done;

  always @(negedge clk) begin
    if (bus.bus_ack === 1'b1 && pend_we)
      for (int i = 0; i < 4; i++)
        if (pend_be[i]) mem[(int'(pend_addr) + i) % 64] = pend_wdata[8*i +: 8];
    bus.bus_ack = 1'b0;
    if (reset || bus.bus_req !== 1'b1) wait_cnt = 0;
    else if (!never_ack && wait_cnt >= resp_delay) begin
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = {mem[(int'(bus.bus_addr)+3)%64], mem[(int'(bus.bus_addr)+2)%64],
                       mem[(int'(bus.bus_addr)+1)%64], mem[int'(bus.bus_addr)%64]};
      pend_we = bus.bus_we; pend_addr = bus.bus_addr;
      pend_wdata = bus.bus_wdata; pend_be = bus.bus_be;
      if (beat_n < 2) begin
        beat_addr[beat_n] = bus.bus_addr; beat_be[beat_n] = bus.bus_be;
        beat_we[beat_n] = bus.bus_we; beat_wdata[beat_n] = bus.bus_wdata;
      end
      beat_n++;
      wait_cnt = 0;
    end else wait_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic int sz(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input bit rd, input bit wr, input logic [2:0] op,
                                 input logic [31:0] a);
    int s = sz(op);
    bit legal;
    if (rd && wr) return 1'b1;
    legal = wr ? (op[1:0] != 2'b11) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    if (longint'(a) + s > 40) return 1'b1;
`ifndef MISALIGNED_SPLIT_EN
    if (a % s != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int ref_beats(input logic [2:0] op, input logic [31:0] a);
`ifdef MISALIGNED_SPLIT_EN
    return ((a % 4) + sz(op) > 4) ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int s = sz(op);
    for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[a + i];
    if (!op[2] && s == 1) v = {{24{v[7]}}, v[7:0]};
    if (!op[2] && s == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < sz(op); i++) ref_mem[a + i] = wd[8*i +: 8];
  endtask

  task automatic poke(input int a, input logic [7:0] b);
    mem[a] = b; ref_mem[a] = b;
  endtask

  // Drives one request from a negedge and samples until the DONE cycle.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int dly, input bit gap);
    MemRead = rd; MemWrite = wr; mem_op = op; Address = a; WriteData = wd;
    resp_delay = dly; beat_n = 0;
    o_stall = 0; o_req = 0; o_fault = 1'b0; o_rdata = 32'h0; o_done = 1'b0;
    #1;
    if (stall) o_stall++;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (stall) begin
        o_stall++;
        if (bus.bus_req) o_req++;
      end else if (o_stall > 0) begin
        o_fault = fault; o_rdata = ReadData; o_done = 1'b1;
        break;
      end
    end
    if (!o_done) begin
      tests_run++; tests_failed++;
      $display("FAIL access_bound: stall never released, addr=%h", a);
    end
    if (gap) begin MemRead = 1'b0; MemWrite = 1'b0; @(negedge clk); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; mem_op = 3'b0;
    Address = 32'h0; WriteData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (ReadData !== 32'h0 || stall !== 1'b0 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_core: rd=%h stall=%b fault=%b, want 0/0/0", ReadData, stall, fault);
    end
    tests_run++;
    if ({bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_be} !== 70'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h be=%h, want all 0",
               bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_be);
    end
    @(negedge clk); reset = 1'b0; exp_rd = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    poke(8, 8'hEF); poke(9, 8'hBE); poke(10, 8'hAD); poke(11, 8'hDE);
    do_access(1, 0, OP_LW, 32'd8, 32'h0, 0, 1);
    tests_run++;
    if (beat_n !== 1 || beat_addr[0] !== 32'd8 || beat_be[0] !== 4'hF || beat_we[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_bus: beats=%0d addr=%h be=%b we=%b, want 1/8/1111/0",
               beat_n, beat_addr[0], beat_be[0], beat_we[0]);
    end
    tests_run++;
    if (o_stall !== 2 || o_rdata !== 32'hDEADBEEF || o_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_result: stall=%0d rd=%h fault=%b, want 2/deadbeef/0", o_stall, o_rdata, o_fault);
    end
    exp_rd = 32'hDEADBEEF;
  endtask

  task automatic test_byte_extend();
    poke(4, 8'h00); poke(5, 8'h80); poke(6, 8'h00); poke(7, 8'h00);
    do_access(1, 0, OP_LB, 32'd5, 32'h0, 1, 1);
    tests_run++;
    if (beat_addr[0] !== 32'd4 || beat_be[0] !== 4'b0010 || o_rdata !== 32'hFFFFFF80 || o_fault) begin
      tests_failed++;
      $display("FAIL lb_signed: addr=%h be=%b rd=%h, want 4/0010/ffffff80", beat_addr[0], beat_be[0], o_rdata);
    end
    do_access(1, 0, OP_LBU, 32'd5, 32'h0, 0, 1);
    tests_run++;
    if (o_rdata !== 32'h00000080 || o_fault) begin
      tests_failed++;
      $display("FAIL lbu_zero: rd=%h, want 00000080", o_rdata);
    end
    exp_rd = 32'h00000080;
  endtask

  task automatic test_store_half();
    do_access(0, 1, 3'b001, 32'd2, 32'h1234ABCD, 0, 1);
    ref_store(3'b001, 32'd2, 32'h1234ABCD);
    tests_run++;
    if (beat_we[0] !== 1'b1 || beat_be[0] !== 4'b1100 || beat_wdata[0] !== 32'hABCDABCD ||
        beat_addr[0] !== 32'd0) begin
      tests_failed++;
      $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h, want 1/1100/abcdabcd/0",
               beat_we[0], beat_be[0], beat_wdata[0], beat_addr[0]);
    end
    tests_run++;
    if (mem[2] !== 8'hCD || mem[3] !== 8'hAB || ReadData !== exp_rd) begin
      tests_failed++;
      $display("FAIL sh_mem: mem[2]=%h mem[3]=%h rd=%h, want cd/ab/%h", mem[2], mem[3], ReadData, exp_rd);
    end
  endtask

  task automatic test_misaligned();
    do_access(1, 0, OP_LW, 32'd6, 32'h0, 0, 1);
`ifdef MISALIGNED_SPLIT_EN
    tests_run++;
    if (beat_n !== 2 || beat_addr[0] !== 32'd4 || beat_be[0] !== 4'b1100 ||
        beat_addr[1] !== 32'd8 || beat_be[1] !== 4'b0011) begin
      tests_failed++;
      $display("FAIL split_beats: n=%0d a0=%h be0=%b a1=%h be1=%b, want 2/4/1100/8/0011",
               beat_n, beat_addr[0], beat_be[0], beat_addr[1], beat_be[1]);
    end
    exp_rd = 32'hBEEF0000;
    tests_run++;
    if (o_rdata !== exp_rd || o_fault !== 1'b0 || o_stall !== 3) begin
      tests_failed++;
      $display("FAIL split_data: rd=%h fault=%b stall=%0d, want %h/0/3", o_rdata, o_fault, o_stall, exp_rd);
    end
`else
    tests_run++;
    if (o_fault !== 1'b1 || o_req !== 0 || o_rdata !== exp_rd || o_stall !== 1) begin
      tests_failed++;
      $display("FAIL misalign_fault: fault=%b req=%0d rd=%h stall=%0d, want 1/0/%h/1",
               o_fault, o_req, o_rdata, o_stall, exp_rd);
    end
`endif
  endtask

  task automatic test_range();
    logic [31:0] e;
    do_access(1, 0, OP_LW, 32'd40, 32'h0, 0, 1);
    tests_run++;
    if (o_fault !== 1'b1 || o_req !== 0 || o_rdata !== exp_rd) begin
      tests_failed++;
      $display("FAIL range_lw40: fault=%b req=%0d rd=%h, want 1/0/%h", o_fault, o_req, o_rdata, exp_rd);
    end
    e = ref_load(OP_LW, 32'd36);
    do_access(1, 0, OP_LW, 32'd36, 32'h0, 2, 1);
    tests_run++;
    if (o_fault !== 1'b0 || o_rdata !== e) begin
      tests_failed++;
      $display("FAIL range_lw36: fault=%b rd=%h, want 0/%h", o_fault, o_rdata, e);
    end
    e = ref_load(OP_LBU, 32'd39);
    do_access(1, 0, OP_LBU, 32'd39, 32'h0, 0, 1);
    tests_run++;
    if (o_fault !== 1'b0 || o_rdata !== e || beat_be[0] !== 4'b1000) begin
      tests_failed++;
      $display("FAIL range_lbu39: fault=%b rd=%h be=%b, want 0/%h/1000", o_fault, o_rdata, beat_be[0], e);
    end
    exp_rd = e;
  endtask

  task automatic test_timeout();
    never_ack = 1'b1;
    do_access(0, 1, OP_LW, 32'd12, 32'hCAFEF00D, 0, 1);
    tests_run++;
    if (o_req !== 15 || o_stall !== 16 || o_fault !== 1'b1 || bus.bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_sw: req=%0d stall=%0d fault=%b busreq=%b, want 15/16/1/0",
               o_req, o_stall, o_fault, bus.bus_req);
    end
    do_access(1, 0, OP_LW, 32'd16, 32'h0, 0, 1);
    tests_run++;
    if (o_fault !== 1'b1 || o_rdata !== exp_rd || o_req !== 15) begin
      tests_failed++;
      $display("FAIL timeout_lw: fault=%b rd=%h req=%0d, want 1/%h/15", o_fault, o_rdata, o_req, exp_rd);
    end
    never_ack = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    do_access(1, 0, OP_LW, 32'd8, 32'h0, 0, 1);
    exp_rd = 32'hDEADBEEF;
    never_ack = 1'b1;
    MemRead = 1'b1; mem_op = OP_LW; Address = 32'd16;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (bus.bus_req !== 1'b1 || ReadData !== exp_rd) begin
      tests_failed++;
      $display("FAIL midreq_pre: busreq=%b rd=%h, want 1/%h", bus.bus_req, ReadData, exp_rd);
    end
    reset = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus.bus_req !== 1'b0 || stall !== 1'b0 || ReadData !== 32'h0 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreq_reset: busreq=%b stall=%b rd=%h fault=%b, want 0/0/0/0",
               bus.bus_req, stall, ReadData, fault);
    end
    @(negedge clk); reset = 1'b0; never_ack = 1'b0; exp_rd = 32'h0;
    @(negedge clk);
    do_access(1, 0, OP_LW, 32'd8, 32'h0, 0, 1);
    tests_run++;
    if (o_stall !== 2 || o_rdata !== 32'hDEADBEEF || o_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreq_recover: stall=%0d rd=%h fault=%b, want 2/deadbeef/0", o_stall, o_rdata, o_fault);
    end
    exp_rd = 32'hDEADBEEF;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d = $urandom;
    do_access(0, 1, OP_LW, 32'd20, d, 0, 0);
    ref_store(OP_LW, 32'd20, d);
    do_access(1, 0, OP_LW, 32'd20, 32'h0, 0, 1);
    tests_run++;
    if (o_rdata !== d || o_stall !== 2 || o_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_sw_lw: rd=%h stall=%0d fault=%b, want %h/2/0", o_rdata, o_stall, o_fault, d);
    end
    exp_rd = d;
  endtask

  task automatic test_random();
    logic [2:0] lops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 80; n++) begin
      int r = $urandom_range(0, 9);
      bit rd, wr, err;
      logic [2:0] op;
      logic [31:0] a, wd, e;
      int dly, nb;
      rd = (r == 1) || (r >= 2 && r[0]);
      wr = (r == 1) || (r >= 2 && !r[0]);
      op = ($urandom_range(0, 9) < 8) ? lops[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 47));
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(sz(op)) - 32'd1);
      wd = $urandom; dly = $urandom_range(0, 3);
      if (!rd && !wr) begin
        MemRead = 1'b0; MemWrite = 1'b0; Address = a;
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || bus.bus_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL rnd_idle: stall=%b busreq=%b, want 0/0", stall, bus.bus_req);
        end
        continue;
      end
      err = ref_err(rd, wr, op, a);
      nb  = ref_beats(op, a);
      e   = (!err && rd) ? ref_load(op, a) : exp_rd;
      do_access(rd, wr, op, a, wd, dly, 1);
      if (!err && wr) ref_store(op, a, wd);
      exp_rd = e;
      tests_run++;
      if (err) begin
        if (o_fault !== 1'b1 || o_req !== 0 || o_stall !== 1 || o_rdata !== e) begin
          tests_failed++;
          $display("FAIL rnd_err: rd=%b wr=%b op=%b a=%0d fault=%b req=%0d stall=%0d data=%h want data %h",
                   rd, wr, op, a, o_fault, o_req, o_stall, o_rdata, e);
        end
      end else if (o_fault !== 1'b0 || o_rdata !== e || o_stall !== 1 + nb*(dly+1) ||
                   o_req !== nb*(dly+1)) begin
        tests_failed++;
        $display("FAIL rnd_ok: rd=%b wr=%b op=%b a=%0d dly=%0d fault=%b data=%h stall=%0d req=%0d, want 0/%h/%0d/%0d",
                 rd, wr, op, a, dly, o_fault, o_rdata, o_stall, o_req, e, 1 + nb*(dly+1), nb*(dly+1));
      end
    end
  endtask

  task automatic test_memory_image();
    int bad = 0;
    for (int i = 0; i < 40; i++) if (mem[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL mem_image: %0d bytes differ from reference, want 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    pend_we = 1'b0; pend_addr = 32'h0; pend_wdata = 32'h0; pend_be = 4'h0;
    test_reset();
    test_load_word();
    test_byte_extend();
    test_store_half();
    test_misaligned();
    test_range();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    test_memory_image();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
Load/store unit: the initiator for the data memory, sitting between the MEM pipeline stage and the word-wide data-memory bus.
Converts MemRead/MemWrite plus an access size into aligned word transactions with byte enables.
Holds the pipeline via stall until the bus acknowledges, and returns sign/zero-extended load data.
Flags misaligned, out-of-range and timed-out accesses.

Parameters:
MEM_BYTES, 40, size of data memory in bytes; any access touching byte >= MEM_BYTES faults
TIMEOUT, 15, max cycles waiting for bus_ack in REQ before fault (4-bit counter)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous active-high reset
MemRead  input  1  load request; held stable by the pipeline while stall=1
MemWrite  input  1  store request; held stable while stall=1
mem_op  input  3  size/sign: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; stores ignore bit 2
Address  input  32  byte address
WriteData  input  32  store data, right-justified
ReadData  output  32  extended load result, valid in DONE, held until the next load completes
stall  output  1  freeze pipeline
fault  output  1  one-cycle pulse in DONE when the access was rejected or timed out
bus_req  output  1  bus request, held until bus_ack
bus_we  output  1  1=write
bus_addr  output  32  word-aligned address (Address & ~3)
bus_wdata  output  32  lane-replicated store data
bus_be  output  4  byte enables; bit i = byte at bus_addr+i (little-endian)
bus_ack  input  1  responder accepts/completes the beat; read data valid same cycle
bus_rdata  input  32  read word

Behaviour:
- Reset values: ReadData=0, stall=0, fault=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, state=IDLE, timeout counter=0.
- States: IDLE, REQ, DONE (plus REQ_HI with the optional feature).
- IDLE:
  - If MemRead or MemWrite: stall=1 combinationally the same cycle.
  - Check the access. Error if: both MemRead and MemWrite set; mem_op not one of the five listed encodings; misaligned (half with Address[0]=1, word with Address[1:0]!=0); or Address+size > MEM_BYTES.
  - Error: go to DONE with fault set and no bus activity.
  - Otherwise: register the bus signals and go to REQ.
- REQ:
  - bus_req=1, stall=1; bus outputs stable until ack.
  - Counter increments each cycle without bus_ack.
  - On bus_ack: capture the extended load data and go to DONE.
  - If the counter reaches TIMEOUT without ack: drop bus_req, go to DONE with fault=1. ReadData is left unchanged.
- DONE: stall=0, bus_req=0, fault pulses if set. Next state is IDLE unconditionally, so back-to-back requests cost one idle-detection cycle.
- Latency: aligned access with immediate ack = 3 cycles stalled-to-released (IDLE, REQ, DONE).
- Byte enables:
  - byte: 1<<Address[1:0]
  - half: 0011 or 1100
  - word: 1111
- Store data: byte is WriteData[7:0] replicated x4; half is WriteData[15:0] replicated x2; word is passed through.
- Load extract: select the lane by Address[1:0]. Sign-extend for ops 000/001; zero-extend for 100/101.
- Neither MemRead nor MemWrite in IDLE: stay IDLE, stall=0.
- Reset mid-REQ: bus_req drops on the next edge and the transaction is abandoned. The responder must tolerate the abandoned request.
- bus_ack outside REQ: ignored.

Optional Feature:
MISALIGNED_SPLIT_EN
- Defined:
  - Misaligned half/word accesses (still range-checked) become two bus beats: REQ, then REQ_HI at bus_addr+4, each with its partial bus_be.
  - Load data is assembled from both beats before DONE; stores write the low lanes, then the high lanes.
  - The timeout counter restarts per beat; a timeout on either beat faults with no partial ReadData update. A write whose first beat already landed is not rolled back.
- Undefined: misaligned access faults as above; REQ_HI does not exist.

Decomposition:
- Package mips_mem_pkg holds:
  - mem_op encodings
  - FSM state enum
  - size constants (BYTE=1, HALF=2, WORD=4)
  - default MEM_BYTES
- Natural combinational sub-module: lsu_lane_align. It generates byte enables, replicates store data, and extracts/extends load lanes. It is reused for both beats under the feature.

Test Plan:
- LW at Address=8, bus_ack in the first REQ cycle, bus_rdata=0xDEADBEEF -> bus_addr=8, bus_be=1111, stall high 2 cycles, ReadData=0xDEADBEEF, fault=0.
- LB at Address=5, bus_rdata=0x0000_8000 -> bus_addr=4, bus_be=0010, ReadData=0xFFFFFF80. Same access with LBU -> ReadData=0x00000080.
- SH at Address=2, WriteData=0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD.
- LW at Address=6 (misaligned, feature off) -> no bus_req, fault pulse, ReadData unchanged. Feature on -> beats at 4 (be 1100) and 8 (be 0011), ReadData={rdata2[15:0], rdata1[31:16]}.
- LW at Address=40 -> fault (range), no bus_req. SW with bus_ack never asserted -> bus_req high 15 cycles, then fault, stall released.
- Reset asserted in the 2nd REQ cycle -> next edge: bus_req=0, stall=0, state IDLE, ReadData=0.
